mem_arbiter: RTL and testbench

- Shares the single 256-bit off-chip data memory port between two cache requesters: port 0 (instruction cache) and port 1 (dcache_top).
- Sits between the caches and the memory model, replacing the direct dcache-to-memory wiring at the CPU top level.
- Serialises whole-line read/write transactions, with round-robin or fixed priority selection.
- A watchdog counter flags any transaction the memory never acknowledges.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/rr_pick2.sv | 26 ++
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port line-memory arbiter.
// State encoding, port indices and grant one-hot values.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int unsigned PORT_I = 0;
    localparam int unsigned PORT_D = 1;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    // One-hot grant for a winning port index.
    function automatic logic [1:0] port2gnt(input logic p);
        return p ? GNT_D : GNT_I;
    endfunction

    // Watchdog counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner select: lone requester wins; ties go to
// the port not served last, or to port 1 under fixed priority.
module rr_pick2
    import mem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_o,
    output logic       valid_o
);

    // Combinational winner index for the current request pair.
    always_comb begin
        valid_o = |req_i;
        win_o   = 1'(PORT_I);
        unique case (req_i)
            2'b01:   win_o = 1'(PORT_I);
            2'b10:   win_o = 1'(PORT_D);
            2'b11:   win_o = FIXED_PRIO ? 1'(PORT_D) : ~last_i;
            default: win_o = 1'(PORT_I);
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one whole-line memory port between icache (port 0) and
// dcache (port 1), with a watchdog on missing memory acks.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 256,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        grant_o,
    output logic              timeout_err_o
);

    localparam int CNT_W   = cnt_width(TIMEOUT);
    localparam int TMO_M1I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_M1I);
    localparam bit WDOG_ON = (TIMEOUT != 0);

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic              men_q, men_d;
    logic              mwe_q, mwe_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [DATA_W-1:0] p0_rd_q, p0_rd_d;
    logic [DATA_W-1:0] p1_rd_q, p1_rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic pick_win;
    logic pick_vld;
    logic owner_d;
    logic tmo_hit;

    rr_pick2 #(
        .FIXED_PRIO(FIXED_PRIO != 0)
    ) u_pick (
        .req_i  ({p1_req_i, p0_req_i}),
        .last_i (last_q),
        .win_o  (pick_win),
        .valid_o(pick_vld)
    );

    assign owner_d = grant_q[PORT_D];
    assign tmo_hit = WDOG_ON && (cnt_q == TMO_LAST);

    // FSM state register; reset abandons any transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: ack beats the watchdog on the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (pick_vld) state_d = ST_BUSY;
            ST_BUSY: if (mem_ack_i || tmo_hit) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: grant capture, completion and watchdog.
    always_comb begin
        grant_d  = grant_q;
        last_d   = last_q;
        men_d    = men_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        p0_rd_d  = p0_rd_q;
        p1_rd_d  = p1_rd_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d  = port2gnt(pick_win);
                    last_d   = pick_win;
                    men_d    = 1'b1;
                    mwe_d    = pick_win ? p1_write_i : p0_write_i;
                    maddr_d  = pick_win ? p1_addr_i : p0_addr_i;
                    mwdata_d = pick_win ? p1_data_i : p0_data_i;
                    cnt_d    = '0;
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    men_d = 1'b0;
                    cnt_d = '0;
                    if (owner_d) p1_rd_d = mem_data_i;
                    else         p0_rd_d = mem_data_i;
                end else if (tmo_hit) begin
                    men_d = 1'b0;
                    cnt_d = '0;
                    err_d = 1'b1;
                    if (owner_d) p1_rd_d = '0;
                    else         p0_rd_d = '0;
                end else if (cnt_q != TMO_LIM) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACK: begin
                grant_d = GNT_NONE;
            end
            default: begin
                grant_d = GNT_NONE;
                men_d   = 1'b0;
            end
        endcase
    end

    // Datapath registers; last pointer resets to port 1.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            grant_q  <= GNT_NONE;
            last_q   <= 1'(PORT_D);
            men_q    <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            p0_rd_q  <= '0;
            p1_rd_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            last_q   <= last_d;
            men_q    <= men_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            p0_rd_q  <= p0_rd_d;
            p1_rd_q  <= p1_rd_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Outputs: acks are decoded from the ACK state and the owner.
    always_comb begin
        p0_ack_o      = (state_q == ST_ACK) && grant_q[PORT_I];
        p1_ack_o      = (state_q == ST_ACK) && grant_q[PORT_D];
        p0_data_o     = p0_rd_q;
        p1_data_o     = p1_rd_q;
        mem_enable_o  = men_q;
        mem_write_o   = mwe_q;
        mem_addr_o    = maddr_q;
        mem_data_o    = mwdata_q;
        grant_o       = grant_q;
        timeout_err_o = err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Round-robin instance plus a fixed-priority instance on shared inputs.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0]  p0_addr = 0, p1_addr = 0;
    logic [255:0] p0_wd = 0, p1_wd = 0;
    logic [255:0] mem_rd = 0;
    logic         mem_ack = 0;

    logic [255:0] p0_rd, p1_rd, m_wd;
    logic         p0_ack, p1_ack, m_en, m_we, err;
    logic [31:0]  m_addr;
    logic [1:0]   gnt;

    logic [255:0] f_p0_rd, f_p1_rd, f_m_wd;
    logic         f_p0_ack, f_p1_ack, f_m_en, f_m_we, f_err;
    logic [31:0]  f_m_addr;
    logic [1:0]   f_gnt;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .p0_req_i(p0_req), .p0_write_i(p0_we),
        .p0_addr_i(p0_addr), .p0_data_i(p0_wd),
        .p0_data_o(p0_rd), .p0_ack_o(p0_ack),
        .p1_req_i(p1_req), .p1_write_i(p1_we),
        .p1_addr_i(p1_addr), .p1_data_i(p1_wd),
        .p1_data_o(p1_rd), .p1_ack_o(p1_ack),
        .mem_enable_o(m_en), .mem_write_o(m_we),
        .mem_addr_o(m_addr), .mem_data_o(m_wd),
        .mem_data_i(mem_rd), .mem_ack_i(mem_ack),
        .grant_o(gnt), .timeout_err_o(err)
    );

    mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(16)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .p0_req_i(p0_req), .p0_write_i(p0_we),
        .p0_addr_i(p0_addr), .p0_data_i(p0_wd),
        .p0_data_o(f_p0_rd), .p0_ack_o(f_p0_ack),
        .p1_req_i(p1_req), .p1_write_i(p1_we),
        .p1_addr_i(p1_addr), .p1_data_i(p1_wd),
        .p1_data_o(f_p1_rd), .p1_ack_o(f_p1_ack),
        .mem_enable_o(f_m_en), .mem_write_o(f_m_we),
        .mem_addr_o(f_m_addr), .mem_data_o(f_m_wd),
        .mem_data_i(mem_rd), .mem_ack_i(mem_ack),
        .grant_o(f_gnt), .timeout_err_o(f_err)
    );

    task automatic do_reset();
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        mem_ack = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Wait n cycles, then present a one-cycle memory ack with data d.
    task automatic mem_pulse(input int n, input logic [255:0] d);
        repeat (n) @(negedge clk);
        mem_ack = 1'b1;
        mem_rd  = d;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_run++;
        if ({m_en, gnt, p0_ack, p1_ack, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 0",
                     {m_en, gnt, p0_ack, p1_ack, err});
        end
        n_run++;
        if ({p0_rd, p1_rd} !== 512'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h want 0", p0_rd, p1_rd);
        end
    endtask

    task automatic test_single_read();
        logic [255:0] pat;
        pat = {8{32'hA5A5_A5A5}};
        do_reset();
        @(negedge clk);
        p1_req = 1; p1_we = 0; p1_addr = 32'h0000_0400;
        @(negedge clk);
        n_run++;
        if ({m_en, m_we, gnt} !== 4'b1010 || m_addr !== 32'h400) begin
            n_fail++;
            $display("FAIL rd_issue: got en%b we%b g%b a%h want 1 0 10 400",
                     m_en, m_we, gnt, m_addr);
        end
        mem_pulse(9, pat);
        n_run++;
        if (p1_ack !== 1'b1 || p1_rd !== pat || p0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_ack: got a1=%b a0=%b d=%h want 1 0 a5..",
                     p1_ack, p0_ack, p1_rd);
        end
        p1_req = 0;
        @(negedge clk);
        n_run++;
        if ({p1_ack, p0_ack, gnt, m_en} !== 5'b0 || p1_rd !== pat) begin
            n_fail++;
            $display("FAIL rd_after: got acks%b%b g%b en%b want 0",
                     p1_ack, p0_ack, gnt, m_en);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]   eg;
        logic [31:0]  ea;
        logic [255:0] pat;
        do_reset();
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 32'h100;
        p1_req = 1; p1_we = 0; p1_addr = 32'h200;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            eg  = (i % 2 == 0) ? 2'b01 : 2'b10;
            ea  = (i % 2 == 0) ? 32'h100 : 32'h200;
            pat = {8{32'(i + 32'h5000)}};
            n_run++;
            if (gnt !== eg || m_en !== 1'b1 || m_addr !== ea) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got g%b en%b a%h want %b 1 %h",
                         i, gnt, m_en, m_addr, eg, ea);
            end
            mem_pulse(2, pat);
            n_run++;
            if ({p1_ack, p0_ack} !== eg ||
                (eg[0] ? p0_rd : p1_rd) !== pat) begin
                n_fail++;
                $display("FAIL rr_ack%0d: got %b%b want %b",
                         i, p1_ack, p0_ack, eg);
            end
            @(negedge clk);
            n_run++;
            if (gnt !== 2'b00 || m_en !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle%0d: got g%b en%b want 00 0",
                         i, gnt, m_en);
            end
            if (i == 5) begin
                p0_req = 0; p1_req = 0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 32'h100;
        p1_req = 1; p1_we = 0; p1_addr = 32'h200;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if (f_gnt !== 2'b10 || f_m_addr !== 32'h200) begin
                n_fail++;
                $display("FAIL fp_grant%0d: got g%b a%h want 10 200",
                         i, f_gnt, f_m_addr);
            end
            mem_pulse(1, {8{32'hF00D_0000 | 32'(i)}});
            n_run++;
            if (f_p1_ack !== 1'b1 || f_p0_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL fp_ack%0d: got %b%b want 10",
                         i, f_p1_ack, f_p0_ack);
            end
            if (i == 2) p1_req = 0;
            repeat (2) @(negedge clk);
        end
        n_run++;
        if (f_gnt !== 2'b01 || f_m_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL fp_p0_late: got g%b a%h want 01 100",
                     f_gnt, f_m_addr);
        end
        mem_pulse(1, {8{32'hCAFE_0001}});
        n_run++;
        if (f_p0_ack !== 1'b1 || f_p0_rd !== {8{32'hCAFE_0001}}) begin
            n_fail++;
            $display("FAIL fp_p0_ack: got %b %h want 1 cafe0001..",
                     f_p0_ack, f_p0_rd);
        end
        p0_req = 0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [255:0] wd;
        wd = {8{32'h1234_5678}};
        do_reset();
        @(negedge clk);
        p0_req = 1; p0_we = 1; p0_addr = 32'h0000_1000; p0_wd = wd;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_run++;
            if (m_en !== 1'b1 || m_we !== 1'b1 ||
                m_addr !== 32'h1000 || m_wd !== wd) begin
                n_fail++;
                $display("FAIL wr_busy%0d: got en%b we%b a%h d%h",
                         i, m_en, m_we, m_addr, m_wd);
            end
        end
        mem_pulse(0, '0);
        n_run++;
        if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack: got %b%b want 01", p1_ack, p0_ack);
        end
        p0_req = 0; p0_we = 0;
        @(negedge clk);
        n_run++;
        if (p0_ack !== 1'b0 || m_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_single: got ack%b en%b want 0 0",
                     p0_ack, m_en);
        end
    endtask

    task automatic test_watchdog();
        int hi;
        bit done;
        do_reset();
        @(negedge clk);
        p1_req = 1; p1_we = 0; p1_addr = 32'h0000_0800;
        @(negedge clk);
        mem_pulse(0, {8{32'hFFFF_FFFF}});
        p1_req = 0;
        repeat (2) @(negedge clk);
        p1_req = 1;
        hi = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (m_en) hi++;
            else if (hi > 0) done = 1;
        end
        n_run++;
        if (!done || hi != 16) begin
            n_fail++;
            $display("FAIL wd_len: got %0d busy cycles done=%0b want 16",
                     hi, done);
        end
        n_run++;
        if (err !== 1'b1 || p1_ack !== 1'b1 || p1_rd !== 256'b0 ||
            p0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_fire: got err%b a1%b a0%b d%h want 1 1 0 0",
                     err, p1_ack, p0_ack, p1_rd);
        end
        p1_req = 0;
        mem_pulse(0, {8{32'hDEAD_BEEF}});
        n_run++;
        if (p1_rd !== 256'b0 || p1_ack !== 1'b0 || m_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_late: got d%h ack%b en%b want 0 0 0",
                     p1_rd, p1_ack, m_en);
        end
        repeat (5) @(negedge clk);
        n_run++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 32'h300;
        @(negedge clk);
        n_run++;
        if (m_en !== 1'b1 || gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL ar_pre: got en%b g%b want 1 01", m_en, gnt);
        end
        #2 rst = 1'b0;
        #1;
        n_run++;
        if ({m_en, gnt, p0_ack, p1_ack, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL ar_async: got %b want 0",
                     {m_en, gnt, p0_ack, p1_ack, err});
        end
        p0_req = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        p0_req = 1; p0_addr = 32'h100;
        p1_req = 1; p1_addr = 32'h200;
        @(negedge clk);
        n_run++;
        if (gnt !== 2'b01 || m_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL ar_tie: got g%b a%h want 01 100", gnt, m_addr);
        end
        mem_pulse(0, '0);
        p0_req = 0; p1_req = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_write();
        test_watchdog();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
